// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-bus types: data word, RAM handshake states and the
// request record used by the RAM responder.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT = 2;

    typedef enum logic {
        RAM_IDLE,
        RAM_WAIT
    } ramfsm_t;

    typedef struct packed {
        logic  rd;
        logic  wr;
        word_t addr;
        word_t data;
    } ramreq_t;

    // Folds the raw strobes into one operation; a write wins over a read.
    function automatic ramreq_t ramMakeReq(logic ren, logic wen, word_t addr, word_t data);
        ramreq_t req;
        req.rd   = ren && !wen;
        req.wr   = wen;
        req.addr = addr;
        req.data = data;
        return req;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Single-ported RAM request bus between the memory controller (master)
// and the RAM responder (slave).
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN,
        output ramWEN,
        output ramaddr,
        output ramstore,
        input  ramload,
        input  ramstate
    );

    modport slave (
        input  ramREN,
        input  ramWEN,
        input  ramaddr,
        input  ramstore,
        output ramload,
        output ramstate
    );

endinterface

// File: rtl/ram_array.sv
// DEPTH x 32 storage with one synchronous write port and one asynchronous
// read port; contents power up to zero and are never reset.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder for the memory controller bus: answers held requests
// after LAT wait cycles. Define RAM_ERR_EN to flag illegal requests with ERROR.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int DEPTH = 1024
) (
    input  logic           CLK,
    input  logic           RST,
    ram_responder_if.slave bus
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [3:0]  LAT_C      = 4'(LAT);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

    ramfsm_t    r_state;
    ramfsm_t    w_stateNext;
    logic [3:0] r_cnt;
    logic [3:0] w_cntNext;
    ramreq_t    r_req;
    ramreq_t    w_reqNext;
    ramreq_t    w_liveReq;
    logic       w_reqPresent;
    logic       w_err;
    logic       w_match;
    logic       w_memWe;
    ramstate_t  w_ramstate;
    word_t      w_rdData;

    assign w_liveReq    = ramMakeReq(bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
    assign w_reqPresent = bus.ramREN || bus.ramWEN;
    assign w_match      = (w_liveReq == r_req);

`ifdef RAM_ERR_EN
    assign w_err = (bus.ramREN && bus.ramWEN)
                || (bus.ramaddr[1:0] != 2'b00)
                || ({1'b0, bus.ramaddr} >= ADDR_LIMIT);
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RAM_IDLE;
            r_cnt   <= 4'd0;
            r_req   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_req   <= w_reqNext;
        end
    end

    // Any change to the held request in WAIT restarts the count on the new one.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_reqNext   = r_req;
        w_ramstate  = FREE;
        w_memWe     = 1'b0;
        case (r_state)
            RAM_IDLE: begin
                if (w_err) begin
                    w_ramstate = ERROR;
                end else if (w_reqPresent) begin
                    w_ramstate  = BUSY;
                    w_reqNext   = w_liveReq;
                    w_cntNext   = 4'd0;
                    w_stateNext = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (w_err) begin
                    w_ramstate  = ERROR;
                    w_stateNext = RAM_IDLE;
                end else if (w_reqPresent && w_match) begin
                    if (r_cnt < LAT_C) begin
                        w_ramstate = BUSY;
                        w_cntNext  = r_cnt + 4'd1;
                    end else begin
                        w_ramstate  = ACCESS;
                        w_memWe     = r_req.wr;
                        w_stateNext = RAM_IDLE;
                    end
                end else if (w_reqPresent) begin
                    w_ramstate = BUSY;
                    w_reqNext  = w_liveReq;
                    w_cntNext  = 4'd0;
                end else begin
                    w_stateNext = RAM_IDLE;
                end
            end
            default: begin
                w_stateNext = RAM_IDLE;
            end
        endcase
        // Reset takes effect on the outputs immediately, not at the next edge.
        if (RST) begin
            w_ramstate = FREE;
            w_memWe    = 1'b0;
        end
    end

    ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK     (CLK),
        .i_we    (w_memWe),
        .i_waddr (r_req.addr[AW+1:2]),
        .i_wdata (r_req.data),
        .i_raddr (r_req.addr[AW+1:2]),
        .o_rdata (w_rdData)
    );

    assign bus.ramstate = w_ramstate;
    assign bus.ramload  = ((w_ramstate == ACCESS) && r_req.rd) ? w_rdData : '0;

endmodule

// File: doc/ram_responder.md
# ram_responder

Behavioural-synthesisable RAM that sits on the RAM side of the memory controller and answers its single-ported request bus (ramREN/ramWEN/ramaddr/ramstore). It returns ramload and the ramstate handshake (FREE/BUSY/ACCESS/ERROR) after a configurable latency. It is the responder end of the bus that the arbiter drives, and is used in both simulation and FPGA builds.

## Interface
Parameters:
- LAT, 2: wait cycles inserted before ACCESS (0..15).
- DEPTH, 1024: storage size in 32-bit words; power of two.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: reset; asynchronous, active-high.
- ramREN, in, 1: read request, held until ACCESS.
- ramWEN, in, 1: write request, held until ACCESS.
- ramaddr, in, 32 (word_t): byte address.
- ramstore, in, 32 (word_t): write data.
- ramload, out, 32 (word_t): read data.
- ramstate, out, ramstate_t: FREE, BUSY, ACCESS or ERROR.

## Operation
- State machine with states IDLE and WAIT, plus a counter cnt of width 4 and registered copies of the op (rd/wr), the address and the store data.
- IDLE:
  - No request: ramstate=FREE.
  - Request present: ramstate=BUSY; at the clock edge, capture op/addr/data, set cnt=0 and go to WAIT.
- WAIT, while the live request matches the captured request (same op, addr and ramstore):
  - cnt<LAT: ramstate=BUSY and cnt++.
  - cnt==LAT: ramstate=ACCESS.
- On the ACCESS cycle edge:
  - Write: commit mem[addr] = captured data.
  - Both ops: return to IDLE.
- WAIT with a mismatch (requester changed or dropped the request): abandon without a memory side effect. ramstate=FREE if no request, otherwise BUSY. Recapture with cnt=0 at the edge (or go to IDLE if no request).
- ramload:
  - Read in ACCESS: mem[addr[log2(DEPTH)+1:2]], combinational from the array.
  - Otherwise: 0.
- Write followed by a read to the same address returns the new data.
- Reset:
  - FSM goes to IDLE, cnt=0, captured registers cleared; ramstate=FREE, ramload=0.
  - Array contents are not reset. Power-up contents are zero.
  - Reset mid-WAIT aborts the transaction; no write commits.

## Timing
- Request first presented in cycle t gives ramstate=BUSY in cycles t..t+LAT and ACCESS in cycle t+LAT+1.
- Latency is LAT+1 cycles. Read data is valid only in the ACCESS cycle.
- The requester may change its request in cycle t+LAT+2. A request still held there is treated as new, so back-to-back requests need no FREE gap.
- ACCESS lasts exactly one cycle per transaction.
- Write takes effect at the end of the ACCESS cycle and is visible to any request that reaches ACCESS later.

## Configuration
- RAM_ERR_EN defined:
  - ramstate=ERROR combinationally, with no transaction and no memory change, for any of these: ramREN&&ramWEN, ramaddr[1:0]!=0, or ramaddr>=DEPTH*4.
  - FSM stays in or returns to IDLE while the error holds.
- RAM_ERR_EN undefined:
  - ERROR is never driven.
  - WEN wins when both REN and WEN are asserted.
  - addr[1:0] is ignored and the address wraps modulo DEPTH.

## Structure
- cpu_types_pkg (shared): word_t, ramstate_t, and the constant RAM_LAT_DEFAULT=2.
- One sub-module, ram_array:
  - DEPTH×32 storage, one write port, one asynchronous read port.
  - Writes are synchronous with a write enable.
- ram_responder holds the FSM, the counter, request compare, error decode and output muxing.

## Test plan
- Read latency: LAT=2, mem[0x40>>2]=0xDEADBEEF preloaded; hold ramREN with ramaddr=0x40 from cycle 0 -> ramstate BUSY in cycles 0–2, ACCESS in cycle 3 with ramload=0xDEADBEEF, and ramload=0 in all other cycles.
- Write then read: ramWEN with ramaddr=0x100 and ramstore=0x12345678 until ACCESS, then immediately ramREN to 0x100 -> second ACCESS returns 0x12345678, with no FREE cycle between the two transactions.
- Abandon: ramWEN to 0x8 with ramstore=0xAA; in cycle 1 switch to ramREN at 0xC -> the write never commits (a later read of 0x8 returns 0), and the read's ACCESS arrives LAT+1 cycles after the switch.
- LAT=0: ramREN to 0x0 -> BUSY in cycle 0, ACCESS in cycle 1.
- Reset mid-WAIT: ramWEN to 0x20 with ramstore=0x55; assert RST asynchronously in cycle 1 -> ramstate=FREE and ramload=0 immediately; a subsequent read of 0x20 returns 0.
- RAM_ERR_EN build, DEPTH=1024:
  - ramREN to 0x1000 -> ERROR.
  - ramREN to 0x2 -> ERROR.
  - ramREN and ramWEN asserted together -> ERROR, with no memory change.
- RAM_ERR_EN undefined build, DEPTH=1024: ramREN to 0x1000 -> ACCESS returns mem[0].
